// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA bits LSB first, stop period; paced by i_tick.
// Outputs are registered: o_tx/o_busy follow an accepted start by one clock, requests are dropped while busy.
module uart_tx #(
  parameter int NB_DATA      = 8,
  parameter int N_OVERSAMPLE = 16,
  parameter int SB_TICK      = 16,
  parameter int NB_TCOUNT    = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_tx_done
);

  localparam int NB_BCNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [NB_TCOUNT-1:0] OS_LAST  = NB_TCOUNT'(N_OVERSAMPLE - 1);
  localparam logic [NB_TCOUNT-1:0] SB_LAST  = NB_TCOUNT'(SB_TICK - 1);
  localparam logic [NB_BCNT-1:0]   BIT_LAST = NB_BCNT'(NB_DATA - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [NB_TCOUNT-1:0] tick_cnt_q, tick_cnt_d;
  logic [NB_BCNT-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NB_DATA-1:0]   shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // A tick arriving in the same IDLE cycle as the request is not counted.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    case (state_q)
      IDLE: begin
        if (i_tx_start) begin
          state_d    = START;
          tick_cnt_d = '0;
          shift_d    = i_data;
        end
      end
      START: begin
        if (i_tick) begin
          if (tick_cnt_q == OS_LAST) begin
            state_d    = DATA;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + NB_TCOUNT'(1);
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (tick_cnt_q == OS_LAST) begin
            tick_cnt_d = '0;
            shift_d    = shift_q >> 1;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + NB_BCNT'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + NB_TCOUNT'(1);
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (tick_cnt_q == SB_LAST) begin
            state_d    = IDLE;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + NB_TCOUNT'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered line changes on the same edge as the FSM.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign o_tx      = tx_q;
  assign o_busy    = busy_q;
  assign o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: tick-counting line model, byte scoreboard, directed corner cases plus random traffic.
module tb_uart_tx;
  localparam int NB          = 8;
  localparam int OS          = 16;
  localparam int SB          = 16;
  localparam int FRAME_TICKS = (1 + NB) * OS + SB;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       tx, busy, done;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int  mdl_left     = 0;
  int  mdl_done_cnt = 0;
  bit  mdl_done_ev  = 1'b0;
  int  tick_mode    = 0;
  int  mon_done_cnt = 0;
  int  b2b_cnt      = 0;

  uart_tx #(.NB_DATA(NB), .N_OVERSAMPLE(OS), .SB_TICK(SB), .NB_TCOUNT(5)) dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .i_tick    (tick),
    .i_tx_start(start),
    .i_data    (data),
    .o_tx      (tx),
    .o_busy    (busy),
    .o_tx_done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Tick source: continuous, random, or one pulse every 163 clocks.
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #1;
      case (tick_mode)
        0: tick = 1'b1;
        1: tick = ($urandom_range(0, 2) == 0);
        2: begin
          tick = (div == 162);
          div  = (div == 162) ? 0 : div + 1;
        end
        default: tick = 1'b0;
      endcase
    end
  end

  // Reference model: a request is taken only when idle; a frame then lasts FRAME_TICKS ticks.
  always @(posedge clk or negedge rst_n) begin
    mdl_done_ev = 1'b0;
    if (!rst_n) begin
      mdl_left = 0;
      exp_q.delete();
    end else if (mdl_left == 0) begin
      if (start) begin
        exp_q.push_back(data);
        mdl_left = FRAME_TICKS;
      end
    end else if (tick) begin
      mdl_left--;
      if (mdl_left == 0) begin
        mdl_done_cnt++;
        mdl_done_ev = 1'b1;
      end
    end
  end

  // Monitor: a falling line opens a frame; every sample is checked against the popped byte.
  initial begin
    bit         in_frame;
    bit         last_done;
    int         n;
    int         pos;
    logic [7:0] cur;
    logic       exp_bit;
    in_frame  = 1'b0;
    last_done = 1'b0;
    n         = 0;
    cur       = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame  = 1'b0;
        last_done = 1'b0;
      end else begin
        if (done === 1'b1) mon_done_cnt++;
        if (!in_frame && tx === 1'b0) begin
          if (exp_q.size() == 0) begin
            check("spurious_frame", 32'(exp_q.size()), 1);
          end else begin
            cur      = exp_q.pop_front();
            in_frame = 1'b1;
            n        = 0;
            if (last_done) b2b_cnt++;
          end
        end
        if (in_frame) begin
          if (n == FRAME_TICKS) begin
            check("done_pulse", done, 1);
            check("busy_at_done", busy, 0);
            check("tx_at_done", tx, 1);
            in_frame = 1'b0;
          end else begin
            pos = n / OS;
            if (pos == 0)       exp_bit = 1'b0;
            else if (pos <= NB) exp_bit = cur[pos-1];
            else                exp_bit = 1'b1;
            check("tx_bit", tx, exp_bit);
            check("busy_in_frame", busy, 1);
            check("done_early", done, 0);
            if (tick) n++;
          end
        end else begin
          check("idle_tx", tx, 1);
          check("idle_busy", busy, 0);
          check("idle_done", done, 0);
        end
        last_done = (done === 1'b1);
      end
    end
  end

  task automatic send(input logic [7:0] d);
    data  = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (mdl_left == 0) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) check("wait_idle_timeout", 0, 1);
  endtask

  initial begin
    int lat;
    int d0;
    int b0;
    bit got;

    // Reset and quiet line
    #12;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #10;
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;

    // Continuous tick, 0xA5, done latency from request
    tick_mode = 0;
    data  = 8'hA5;
    start = 1'b1;
    got   = 1'b0;
    lat   = 0;
    for (int k = 1; k <= 400 && !got; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) start = 1'b0;
      if (done === 1'b1) begin
        got = 1'b1;
        lat = k;
      end
    end
    check("done_latency", lat, 161);
    repeat (3) @(posedge clk);
    #1;

    // Slow baud tick, 0x00
    tick_mode = 2;
    send(8'h00);
    wait_idle(30000);
    repeat (3) @(posedge clk);
    #1;

    // Request mid-frame must be ignored
    tick_mode = 0;
    d0 = mon_done_cnt;
    send(8'hF0);
    repeat (60) @(posedge clk);
    #1;
    send(8'h3C);
    wait_idle(400);
    repeat (5) @(posedge clk);
    #1;
    check("single_done", mon_done_cnt - d0, 1);

    // Start held high: back-to-back frames, data swapped in the done cycle
    b0    = b2b_cnt;
    data  = 8'h55;
    start = 1'b1;
    got   = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(posedge clk);
      #1;
      if (mdl_done_ev) begin
        data = 8'hAA;
        got  = 1'b1;
      end
    end
    check("first_frame_done", got, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(400);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_contiguous", b2b_cnt - b0, 1);

    // Reset during data bit 3, then a clean frame
    send(8'hC3);
    repeat (70) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h81);
    wait_idle(400);

    // Random traffic, requests often land while busy
    for (int seg = 0; seg < 6; seg++) begin
      tick_mode = $urandom_range(0, 1);
      for (int c = 0; c < 800; c++) begin
        start = ($urandom_range(0, 7) == 0);
        data  = 8'($urandom);
        @(posedge clk);
        #1;
      end
      start = 1'b0;
    end

    wait_idle(3000);
    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    check("done_count", mon_done_cnt, mdl_done_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
